// File: rtl/mesh_input_buffer_pkg.sv
// Shared mesh packet field offsets and output-port encoding.
// Imported by the input buffer, its route calculator and the bus interface.
package mesh_pkg;

  localparam int unsigned PKT_W     = 64;
  localparam int unsigned VC_BIT    = 63;
  localparam int unsigned XDIR_BIT  = 62;
  localparam int unsigned YDIR_BIT  = 61;
  localparam int unsigned HX_LSB    = 52;
  localparam int unsigned HY_LSB    = 48;
  localparam int unsigned HOP_W     = 4;

  localparam int unsigned PORT_E     = 0;
  localparam int unsigned PORT_W     = 1;
  localparam int unsigned PORT_N     = 2;
  localparam int unsigned PORT_S     = 3;
  localparam int unsigned PORT_LOCAL = 4;
  localparam int unsigned NUM_PORTS  = 5;

  typedef logic [NUM_PORTS-1:0] port_req_t;

endpackage

// File: rtl/mesh_input_buffer_if.sv
// Link/allocator-side bundle of the router input buffer.
// master = link + switch allocator, slave = input buffer.
interface mesh_input_buffer_if #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0]              di;
  logic                          si;
  logic                          ri;
  logic [mesh_pkg::NUM_PORTS-1:0] req;
  logic                          gnt;
  logic [WIDTH-1:0]              dout;
  logic [CNT_W-1:0]              count;
  logic                          err;

  modport master (output di, si, gnt, input ri, req, dout, count, err);
  modport slave  (input di, si, gnt, output ri, req, dout, count, err);

endinterface

// File: rtl/mesh_input_buffer_route_calc.sv
// Combinational XY route computation: one-hot port request plus hop-decremented packet.
// Shared by every router input port.
module mesh_route_calc #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned HOP_W = 4
) (
  input  logic                           i_valid,
  input  logic [WIDTH-1:0]               i_head,
  output logic [mesh_pkg::NUM_PORTS-1:0] o_req,
  output logic [WIDTH-1:0]               o_dout
);
  import mesh_pkg::*;

  logic [HOP_W-1:0] w_hx;
  logic [HOP_W-1:0] w_hy;

  assign w_hx = i_head[HX_LSB +: HOP_W];
  assign w_hy = i_head[HY_LSB +: HOP_W];

  // X is exhausted first, then Y; only the hop field being consumed is decremented
  always_comb begin
    o_req  = '0;
    o_dout = '0;
    if (i_valid) begin
      o_dout = i_head;
      if (w_hx != '0) begin
        if (i_head[XDIR_BIT]) o_req[PORT_W] = 1'b1;
        else                  o_req[PORT_E] = 1'b1;
        o_dout[HX_LSB +: HOP_W] = w_hx - HOP_W'(1);
      end else if (w_hy != '0) begin
        if (i_head[YDIR_BIT]) o_req[PORT_S] = 1'b1;
        else                  o_req[PORT_N] = 1'b1;
        o_dout[HY_LSB +: HOP_W] = w_hy - HOP_W'(1);
      end else begin
        o_req[PORT_LOCAL] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mesh_input_buffer.sv
// Router input channel: FIFO of link packets with XY route request on the head.
// ri depends only on the registered occupancy, so there is no gnt-to-ri path.
module mesh_input_buffer #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned HOP_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  mesh_input_buffer_if.slave  bus
);
  import mesh_pkg::*;

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0]     r_wptr;
  logic [PTR_W-1:0]     r_rptr;
  logic [CNT_W-1:0]     r_count;
  logic                 r_err;

  logic                 w_ri;
  logic                 w_not_empty;
  logic                 w_push;
  logic                 w_pop;
  logic [NUM_PORTS-1:0] w_req;
  logic [WIDTH-1:0]     w_dout;

  assign w_ri        = (r_count != CNT_W'(DEPTH));
  assign w_not_empty = (r_count != '0);
  assign w_push      = bus.si & w_ri;
  assign w_pop       = bus.gnt & w_not_empty;

  // Storage and pointers; power-of-two depth lets pointers wrap naturally
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= bus.di;
        r_wptr        <= r_wptr + PTR_W'(1);
      end
      if (w_pop) r_rptr <= r_rptr + PTR_W'(1);
    end
  end

  // Occupancy and sticky grant-while-empty error
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (bus.gnt && !w_not_empty) r_err <= 1'b1;
    end
  end

  mesh_route_calc #(
    .WIDTH (WIDTH),
    .HOP_W (HOP_W)
  ) u_route_calc (
    .i_valid (w_not_empty),
    .i_head  (r_mem[r_rptr]),
    .o_req   (w_req),
    .o_dout  (w_dout)
  );

  assign bus.ri    = w_ri;
  assign bus.req   = w_req;
  assign bus.dout  = w_dout;
  assign bus.count = r_count;
  assign bus.err   = r_err;

endmodule
